issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_if.sv | 38 +++
 rtl/issue_queue.sv | 96 +++++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// Fetch-side push handshake, reservation-station status and issue bus of the issue queue.
interface issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ins_valid;
  logic [31:0]   ins;
  logic          ins_ready;
  logic          flush;
  logic          rs_alu_free;
  logic          rs_mem_free;
  logic          issue_valid;
  logic          issue_unit;
  logic [5:0]    issue_op;
  logic [5:0]    issue_func;
  logic [4:0]    issue_sftamt;
  logic [4:0]    issue_rs;
  logic [4:0]    issue_rt;
  logic [4:0]    issue_rd;
  logic [15:0]   issue_immd16;
  logic          illegal;
  logic [CW-1:0] count;

  // Fetch/dispatch side: offers instructions, flushes, reports station status.
  modport master (
    output ins_valid, ins, flush, rs_alu_free, rs_mem_free,
    input  ins_ready, issue_valid, issue_unit, issue_op, issue_func, issue_sftamt,
           issue_rs, issue_rt, issue_rd, issue_immd16, illegal, count
  );

  // Queue side.
  modport slave (
    input  ins_valid, ins, flush, rs_alu_free, rs_mem_free,
    output ins_ready, issue_valid, issue_unit, issue_op, issue_func, issue_sftamt,
           issue_rs, issue_rt, issue_rd, issue_immd16, illegal, count
  );
endinterface

// File: rtl/issue_queue.sv
// In-order MIPS instruction issue queue: circular buffer feeding the ALU and
// load/store reservation stations one instruction per cycle. Unsupported
// opcodes are dropped at the head with a one-cycle illegal pulse.
module issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic [31:0] head_word;
  logic        empty;
  logic        cls_alu;
  logic        cls_mem;
  logic        push;
  logic        pop_issue;
  logic        pop_illegal;
  logic        pop;

  assign head_word     = mem[head];
  assign empty         = (count == '0);
  assign bus.ins_ready = (count < CW'(DEPTH));
  assign bus.count     = count;
  assign push          = bus.ins_valid && bus.ins_ready;

  // Decode the head entry's class from its opcode.
  always_comb begin
    cls_alu = 1'b0;
    cls_mem = 1'b0;
    unique case (head_word[31:26])
      6'h00, 6'h08, 6'h0C, 6'h0D: cls_alu = 1'b1;
      6'h23, 6'h2B:               cls_mem = 1'b1;
      default: ;
    endcase
  end

  // A legal head leaves only when its station can take it; an illegal head always leaves.
  assign pop_issue   = !empty && ((cls_alu && bus.rs_alu_free) || (cls_mem && bus.rs_mem_free));
  assign pop_illegal = !empty && !cls_alu && !cls_mem;
  assign pop         = pop_issue || pop_illegal;

  // Entry storage; contents need no reset because only pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[tail] <= bus.ins;
  end

  // Pointers, occupancy and the registered issue bus; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.issue_valid  <= 1'b0;
      bus.illegal      <= 1'b0;
      bus.issue_unit   <= 1'b0;
      bus.issue_op     <= '0;
      bus.issue_func   <= '0;
      bus.issue_sftamt <= '0;
      bus.issue_rs     <= '0;
      bus.issue_rt     <= '0;
      bus.issue_rd     <= '0;
      bus.issue_immd16 <= '0;
    end else if (bus.flush) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      bus.issue_valid <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      bus.issue_valid <= pop_issue;
      bus.illegal     <= pop_illegal;
      if (pop_issue) begin
        bus.issue_unit   <= cls_mem;
        bus.issue_op     <= head_word[31:26];
        bus.issue_func   <= head_word[5:0];
        bus.issue_sftamt <= head_word[10:6];
        bus.issue_rs     <= head_word[25:21];
        bus.issue_rt     <= head_word[20:16];
        bus.issue_rd     <= head_word[15:11];
        bus.issue_immd16 <= head_word[15:0];
      end
    end
  end
endmodule
